// File: rtl/fclk_period_decoder.sv
// Receiver for the variable-period slow clock: measures fclk_in half-periods, classifies
// them as 1..4-unit symbols, tracks the A/B phase pattern and counts errors.
// Optional FDEC_BCD_MIRROR_EN mirrors the generator's BCD up/down counters.
module fclk_period_decoder #(
    parameter int unsigned UNIT_CYC = 1000,
    parameter int unsigned TOL      = 50,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fclk_in,
    output logic             sym_valid,
    output logic [1:0]       sym,
    output logic [CNT_W-1:0] sym_len,
    output logic [1:0]       phase,
    output logic             lock,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic [3:0]       bcd_up,
    output logic [3:0]       bcd_down
);

    localparam int unsigned SatCnt = 4 * UNIT_CYC + TOL + 1;
    localparam logic [CNT_W-1:0] SatVal = CNT_W'(SatCnt);
    localparam logic [CNT_W-1:0] SatM1  = CNT_W'(SatCnt - 1);

    typedef enum logic [1:0] {
        StHunt = 2'd0,
        StPhA  = 2'd1,
        StPhB  = 2'd2
    } state_e;

    logic             s1_q, s2_q, s3_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             meas_vld_q, meas_vld_d;
    logic [CNT_W-1:0] meas_len_q, meas_len_d;
    state_e           state_q, state_d, seed, nxt;
    logic [1:0]       prev_q, prev_d;
    logic [2:0]       conf_q, conf_d;
    logic             sym_valid_q, sym_valid_d;
    logic [1:0]       sym_q, sym_d;
    logic [CNT_W-1:0] sym_len_q, sym_len_d;
    logic             err_q, err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             edge_det, timeout, cls_ok, acc;
    logic [1:0]       cls_sym;
    int               len_v;

    assign edge_det = s2_q ^ s3_q;
    // Fires once, on the cycle the counter steps into saturation.
    assign timeout  = (cnt_q == SatM1);

    // Measurement stage: acts on the edge-detect cycle.
    always_comb begin
        cnt_d      = (cnt_q == SatVal) ? cnt_q : cnt_q + CNT_W'(1);
        first_d    = first_q;
        meas_vld_d = 1'b0;
        meas_len_d = meas_len_q;
        if (timeout) begin
            first_d = 1'b1;
        end else if (edge_det) begin
            cnt_d = '0;
            if (first_q) begin
                first_d = 1'b0;
            end else begin
                meas_vld_d = 1'b1;
                meas_len_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        cls_ok  = 1'b0;
        cls_sym = 2'd0;
        len_v   = int'(meas_len_q);
        for (int k = 1; k <= 4; k++) begin
            if (len_v >= k * int'(UNIT_CYC) - int'(TOL) &&
                len_v <= k * int'(UNIT_CYC) + int'(TOL)) begin
                cls_ok  = 1'b1;
                cls_sym = 2'(k - 1);
            end
        end
    end

    always_comb begin
        seed = (cls_sym == 2'd0 || cls_sym == 2'd3) ? StPhA : StPhB;
        acc  = 1'b0;
        nxt  = seed;
        unique case (state_q)
            StPhA: begin
                if (prev_q == 2'd0 && cls_sym == 2'd3) begin
                    acc = 1'b1;
                    nxt = StPhA;
                end else if (prev_q == 2'd0 && cls_sym == 2'd2) begin
                    acc = 1'b1;
                    nxt = StPhB;
                end else if (prev_q == 2'd3 && cls_sym == 2'd0) begin
                    acc = 1'b1;
                    nxt = StPhA;
                end else if (prev_q == 2'd3 && cls_sym == 2'd1) begin
                    acc = 1'b1;
                    nxt = StPhB;
                end
            end
            StPhB: begin
                if (cls_sym == 2'd0) begin
                    acc = 1'b1;
                    nxt = StPhA;
                end else if ((prev_q == 2'd2 && cls_sym == 2'd1) ||
                             (prev_q == 2'd1 && cls_sym == 2'd2)) begin
                    acc = 1'b1;
                    nxt = StPhB;
                end
            end
            default: acc = 1'b1;
        endcase
    end

    // Pattern stage: one cycle after edge detect.
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        conf_d      = conf_q;
        sym_valid_d = 1'b0;
        sym_d       = sym_q;
        sym_len_d   = sym_len_q;
        err_d       = 1'b0;
        if (timeout) begin
            err_d   = 1'b1;
            state_d = StHunt;
            conf_d  = 3'd0;
        end else if (meas_vld_q) begin
            if (!cls_ok) begin
                err_d   = 1'b1;
                state_d = StHunt;
                conf_d  = 3'd0;
            end else begin
                sym_valid_d = 1'b1;
                sym_d       = cls_sym;
                sym_len_d   = meas_len_q;
                prev_d      = cls_sym;
                state_d     = nxt;
                if (acc) begin
                    conf_d = (conf_q == 3'd4) ? conf_q : conf_q + 3'd1;
                end else begin
                    err_d  = 1'b1;
                    conf_d = 3'd0;
                end
            end
        end
        err_cnt_d = (err_d && err_cnt_q != 8'd255) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            cnt_q       <= '0;
            first_q     <= 1'b1;
            meas_vld_q  <= 1'b0;
            meas_len_q  <= '0;
            state_q     <= StHunt;
            prev_q      <= 2'd0;
            conf_q      <= 3'd0;
            sym_valid_q <= 1'b0;
            sym_q       <= 2'd0;
            sym_len_q   <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            s1_q        <= fclk_in;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            meas_vld_q  <= meas_vld_d;
            meas_len_q  <= meas_len_d;
            state_q     <= state_d;
            prev_q      <= prev_d;
            conf_q      <= conf_d;
            sym_valid_q <= sym_valid_d;
            sym_q       <= sym_d;
            sym_len_q   <= sym_len_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym       = sym_q;
    assign sym_len   = sym_len_q;
    assign phase     = state_q;
    assign lock      = (conf_q == 3'd4);
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

`ifdef FDEC_BCD_MIRROR_EN
    logic [3:0] bcd_up_q, bcd_down_q;
    logic       fclk_rise;

    assign fclk_rise = s2_q & ~s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_up_q   <= 4'd0;
            bcd_down_q <= 4'd9;
        end else if (fclk_rise) begin
            bcd_up_q   <= (bcd_up_q == 4'd9) ? 4'd0 : bcd_up_q + 4'd1;
            bcd_down_q <= (bcd_down_q == 4'd0) ? 4'd9 : bcd_down_q - 4'd1;
        end
    end

    assign bcd_up   = bcd_up_q;
    assign bcd_down = bcd_down_q;
`else
    assign bcd_up   = 4'd0;
    assign bcd_down = 4'd9;
`endif

endmodule

// File: tb/tb_fclk_period_decoder.sv
// Directed bench for fclk_period_decoder with UNIT_CYC=20, TOL=2, CNT_W=8.
module tb_fclk_period_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fclk_in = 1'b0;
    logic       sym_valid;
    logic [1:0] sym;
    logic [7:0] sym_len;
    logic [1:0] phase;
    logic       lock;
    logic       err;
    logic [7:0] err_cnt;
    logic [3:0] bcd_up;
    logic [3:0] bcd_down;

    int n_total = 0;
    int n_bad   = 0;
    int sv_seen = 0;
    int err_seen = 0;
    int elapsed = 0;
    int err_at = 0;
    logic [1:0] last_sym = 2'd0;
    logic [7:0] last_len = 8'd0;

    fclk_period_decoder #(
        .UNIT_CYC(20),
        .TOL     (2),
        .CNT_W   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fclk_in  (fclk_in),
        .sym_valid(sym_valid),
        .sym      (sym),
        .sym_len  (sym_len),
        .phase    (phase),
        .lock     (lock),
        .err      (err),
        .err_cnt  (err_cnt),
        .bcd_up   (bcd_up),
        .bcd_down (bcd_down)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (sym_valid) begin
            sv_seen++;
            last_sym = sym;
            last_len = sym_len;
        end
        if (err) err_seen++;
    endtask

    // Ends the current half-period after len clocks in total, then watches the result window.
    task automatic hp(input string tag, input int len, input int e_sv, input int e_sym,
                      input int e_err, input int e_ph, input int e_lock);
        repeat (len - elapsed) tick();
        fclk_in  = ~fclk_in;
        sv_seen  = 0;
        err_seen = 0;
        repeat (6) tick();
        elapsed = 6;
        chk({tag, ".sv"}, sv_seen, e_sv);
        if (e_sv != 0) begin
            chk({tag, ".sym"}, last_sym, e_sym);
            chk({tag, ".len"}, last_len, len);
        end
        chk({tag, ".err"}, err_seen, e_err);
        chk({tag, ".phase"}, phase, e_ph);
        chk({tag, ".lock"}, lock, e_lock);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst.sym_valid", sym_valid, 0);
        chk("rst.sym", sym, 0);
        chk("rst.sym_len", sym_len, 0);
        chk("rst.phase", phase, 0);
        chk("rst.lock", lock, 0);
        chk("rst.err", err, 0);
        chk("rst.err_cnt", err_cnt, 0);
        chk("rst.bcd_up", bcd_up, 0);
        chk("rst.bcd_down", bcd_down, 9);
        rst = 1'b0;

        // Idle input: single timeout error once the counter saturates at 83.
        sv_seen  = 0;
        err_seen = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (err && err_at == 0) err_at = i;
        end
        chk("idle.sv", sv_seen, 0);
        chk("idle.err_n", err_seen, 1);
        chk("idle.err_at", err_at, 83);
        chk("idle.err_cnt", err_cnt, 1);
        chk("idle.phase", phase, 0);

        // First edge only starts measurement.
        fclk_in  = 1'b1;
        sv_seen  = 0;
        err_seen = 0;
        repeat (6) tick();
        elapsed = 6;
        chk("first.sv", sv_seen, 0);
        chk("first.err", err_seen, 0);

        hp("a0", 20, 1, 0, 0, 1, 0);
        hp("a1", 80, 1, 3, 0, 1, 0);
        hp("a2", 20, 1, 0, 0, 1, 0);
        hp("a3", 80, 1, 3, 0, 1, 1);

        hp("b0", 20, 1, 0, 0, 1, 1);
        hp("b1", 80, 1, 3, 0, 1, 1);
        hp("b2", 40, 1, 1, 0, 2, 1);
        hp("b3", 60, 1, 2, 0, 2, 1);
        hp("b4", 40, 1, 1, 0, 2, 1);
        hp("b5", 20, 1, 0, 0, 1, 1);

        hp("bad50", 50, 0, 0, 1, 0, 0);
        chk("bad50.err_cnt", err_cnt, 2);
        hp("seed80", 80, 1, 3, 0, 1, 0);

        hp("c0", 20, 1, 0, 0, 1, 0);
        hp("c1", 20, 1, 0, 1, 1, 0);
        chk("c1.err_cnt", err_cnt, 3);

        // Tolerance edges: 82 and 18 classify, 23 does not.
        hp("tol82", 82, 1, 3, 0, 1, 0);
        hp("tol18", 18, 1, 0, 0, 1, 0);
        hp("tol23", 23, 0, 0, 1, 0, 0);
        chk("tol23.err_cnt", err_cnt, 4);

        // Mirror: 12 rising edges, half-period 20 -> one seed then 22 pattern errors.
        fclk_in = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 24; i++) begin
            fclk_in = ~fclk_in;
            repeat (20) tick();
        end
`ifdef FDEC_BCD_MIRROR_EN
        chk("bcd.up", bcd_up, 2);
        chk("bcd.down", bcd_down, 7);
`else
        chk("bcd.up", bcd_up, 0);
        chk("bcd.down", bcd_down, 9);
`endif
        chk("bcd.err_cnt", err_cnt, 22);
        chk("bcd.sym_len", sym_len, 20);
        chk("bcd.phase", phase, 1);

        // Asynchronous reset mid-period, checked before the next clock edge.
        repeat (7) tick();
        rst = 1'b1;
        #2;
        chk("arst.bcd_up", bcd_up, 0);
        chk("arst.bcd_down", bcd_down, 9);
        chk("arst.err_cnt", err_cnt, 0);
        chk("arst.sym_len", sym_len, 0);
        chk("arst.phase", phase, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
